tp_gpio_arbiter: RTL
====================

// Module: tp_gpio_arbiter
// PURPOSE
//  Shares the 8-bit test-point PIO slave (addr 0 = data, 4 = bit-set, 5 = bit-clear) between NREQ hardware requesters.
//  Arbitrates round-robin and issues single-cycle Avalon-MM writes to the PIO s1 port.
//  Supports a PULSE op: set bits, hold, then clear.
//  Keeps a shadow copy of the PIO output register for local readback.
// PARAMETERS
//  NREQ          4    number of requesters (2..8)
//  PULSE_CYCLES  16   HOLD length for PULSE op, in clk cycles (>=1)
//  CW            8    width of the hold counter (2**CW > PULSE_CYCLES)
// PORTS
//  clk             in   1        clock
//  reset_n         in   1        async active-low reset
//  req             in   NREQ     request per requester; held high until its ack
//  req_op          in   2*NREQ   op per requester [2i+1:2i]: 00 WRITE, 01 SET, 10 CLEAR, 11 PULSE
//  req_data        in   8*NREQ   data/mask per requester [8i+7:8i]
//  ack             out  NREQ     one-cycle completion pulse to the granted requester
//  busy            out  1        high in every state except IDLE
//  gpio_shadow     out  8        mirror of the PIO output register
//  avm_address     out  3        PIO address
//  avm_chipselect  out  1        PIO chipselect
//  avm_write_n     out  1        PIO write strobe, active low
//  avm_writedata   out  32       {24'b0, data}
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation):
//   - state=IDLE; ack=0; busy=0; gpio_shadow=0; avm_chipselect=0; avm_write_n=1; avm_address=0; avm_writedata=0.
//   - last_grant=NREQ-1, so requester 0 has first priority.
//  FSM states: IDLE, ISSUE, HOLD, ISSUE_CLR, ACK.
//  IDLE:
//   - If any req is high, grant the first set bit searching upward from (last_grant+1) mod NREQ.
//   - Latch grant index g, op and data; last_grant<=g; go to ISSUE.
//  ISSUE (exactly 1 cycle): avm_chipselect=1, avm_write_n=0, avm_writedata={24'b0,data}.
//   - WRITE: addr 0; shadow<=data.
//   - SET:   addr 4; shadow<=shadow|data.
//   - CLEAR: addr 5; shadow<=shadow&~data.
//   - PULSE: addr 4; shadow<=shadow|data.
//   - Next state: HOLD if PULSE, else ACK.
//  HOLD: bus idle (chipselect=0, write_n=1) for exactly PULSE_CYCLES cycles (counter loaded on entry), then ISSUE_CLR.
//  ISSUE_CLR (1 cycle): addr 5, data; shadow<=shadow&~data; then ACK.
//  ACK (1 cycle): ack[g]=1, all other ack bits 0; then IDLE.
//  Latency, req seen in IDLE at cycle 0:
//   - WRITE/SET/CLEAR: write strobe in cycle 1, ack in cycle 2, IDLE in cycle 3.
//   - PULSE: set strobe in cycle 1, clear strobe in cycle PULSE_CYCLES+2, ack one cycle later.
//  Request rules:
//   - Op and data are latched at grant; later changes to req_op/req_data or dropping req are ignored and the op completes.
//   - A req still high in the cycle after ack is a new request, but the round-robin pointer has already advanced.
//  Arithmetic/width:
//   - The bus carries at most one write per cycle; chipselect is never asserted outside ISSUE/ISSUE_CLR.
//   - avm_writedata[31:8] is always 0.
//  PULSE with data=0: both writes are still issued; shadow is unchanged.
//  PULSE overlapping prior bits: the clear removes data bits even if they were set before the pulse.
// TESTING
//  T1 reset: outputs at reset values; req=0001 op0=WRITE data0=0xA5 -> strobe addr0 wd=0xA5 in cycle 1, ack=0001 in cycle 2, shadow=0xA5.
//  T2 set/clear: shadow=0xA5; SET 0x0A -> addr4, shadow=0xAF; CLEAR 0x81 -> addr5, shadow=0x2E.
//  T3 round-robin: req=1111 held continuously -> ack order 0,1,2,3,0; each grant 3 cycles apart.
//  T4 pulse: PULSE_CYCLES=16, PULSE 0x01 from shadow 0 -> addr4 wd 0x01 at cycle 1, addr5 wd 0x01 at cycle 18, ack at cycle 19, shadow=0.
//  T5 req dropped: req0 dropped in cycle 1 of a PULSE -> full sequence and ack still occur; data change after grant is ignored.
//  T6 reset mid-HOLD: reset_n low -> chipselect=0, busy=0, shadow=0 immediately; after release, a new req is served from requester 0.

Source files
------------

// File: rtl/tp_gpio_arbiter_if.sv
// Requester handshake plus Avalon-MM write port of the test-point GPIO arbiter.
// slave: arbiter side; master: requesters / bus observer side.
interface tp_gpio_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [7:0]        gpio_shadow;
  logic [2:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [31:0]       avm_writedata;

  modport slave (
    input  req, req_op, req_data,
    output ack, busy, gpio_shadow,
    output avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport master (
    output req, req_op, req_data,
    input  ack, busy, gpio_shadow,
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/tp_gpio_arbiter.sv
// Round-robin arbiter sharing the 8-bit test-point PIO between NREQ requesters.
// Issues single-cycle PIO writes (WRITE/SET/CLEAR/PULSE) and mirrors the PIO output register.
module tp_gpio_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned CW           = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  tp_gpio_arbiter_if.slave  bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_PULSE = 2'b11;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_ISSUE_CLR,
    S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            cs_q, cs_d;
  logic            write_n_q, write_n_d;
  logic [2:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;

  logic            found_c;
  logic [IW-1:0]   pick_c;

  // First pending request searching upward from the requester after the last grant.
  always_comb begin : rr_search
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = last_q;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_q) + k) % NREQ;
      if (!found_c && bus.req[IW'(idx)]) begin
        found_c = 1'b1;
        pick_c  = IW'(idx);
      end
    end
  end

  // Next state, latched request, hold counter and shadow register.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          last_d  = pick_c;
          op_d    = bus.req_op[{pick_c, 1'b0} +: 2];
          data_d  = bus.req_data[{pick_c, 3'b000} +: 8];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_WRITE: shadow_d = data_q;
          OP_CLEAR: shadow_d = shadow_q & ~data_q;
          default:  shadow_d = shadow_q | data_q;
        endcase
        if (op_q == OP_PULSE) begin
          state_d = S_HOLD;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end else begin
          state_d = S_ACK;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_ISSUE_CLR;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ISSUE_CLR: begin
        shadow_d = shadow_q & ~data_q;
        state_d  = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they belong to.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    ack_d     = '0;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    addr_d    = ADDR_DATA;
    wdata_d   = 8'h00;

    case (state_d)
      S_ISSUE: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = data_d;
        case (op_d)
          OP_WRITE: addr_d = ADDR_DATA;
          OP_CLEAR: addr_d = ADDR_CLR;
          default:  addr_d = ADDR_SET;
        endcase
      end
      S_ISSUE_CLR: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = data_d;
        addr_d    = ADDR_CLR;
      end
      S_ACK:   ack_d[last_d] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NREQ - 1);
      op_q      <= 2'b00;
      data_q    <= 8'h00;
      cnt_q     <= '0;
      shadow_q  <= 8'h00;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      addr_q    <= 3'd0;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      op_q      <= op_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
      write_n_q <= write_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.busy           = busy_q;
  assign bus.gpio_shadow    = shadow_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = {24'h000000, wdata_q};

endmodule
